hazard_unit: RTL

- Responder side of the pipelined controller's hazard interface.
- Consumes RegWriteM, MemtoRegE and PCWrPendingF from the controller, plus register addresses from the datapath. Returns StallF/D/E/M, FlushD/E/W and the forwarding selects.
- Adds a data-memory wait FSM that freezes the pipeline while the data cache is not ready, a sticky wait-timeout flag and a saturating stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Hazard responder for the pipelined core: operand forwarding selects,
// load-use interlock, branch/PC-write flushes and a data-memory wait FSM.
// The wait FSM freezes F/D/E/M and bubbles Writeback while the data cache
// is busy. It also keeps a sticky wait-timeout flag and a saturating count
// of memory-stall cycles.
module hazard_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemAccessM,
    input  logic             DmemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(TIMEOUT);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              ldr_stall;
    logic              mem_stall;

    // Forwarding select for one Execute source operand. The Memory stage holds
    // the younger result, so it wins when both later stages match.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic       we_m,
        input logic [3:0] wa_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (ra == wa_m)) begin
            sel = 2'b10;
        end else if (we_w && (ra == wa_w)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Increment that sticks at the ceiling value instead of wrapping.
    function automatic logic [WC_W-1:0] sat_inc_wait(input logic [WC_W-1:0] v);
        return (v >= WAIT_MAX) ? WAIT_MAX : v + WC_W'(1);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Forwarding muxes for both Execute source operands.
    always_comb begin
        ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
        ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
    end

    // Load-use interlock and memory-wait detection.
    always_comb begin
        ldr_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
        // In MEMWAIT the Memory stage is frozen, so MemAccessM is no longer
        // meaningful; only the cache ready releases the pipeline.
        if (state_q == RUN) begin
            mem_stall = MemAccessM && !DmemReadyM;
        end else begin
            mem_stall = !DmemReadyM;
        end
    end

    // Stall/flush outputs. A memory stall freezes everything up to M and
    // withholds D/E flushes; a taken branch stays asserted while E is frozen,
    // so its flush lands on the first released cycle.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall || PCWrPendingF;
            StallD = ldr_stall;
            FlushD = PCWrPendingF || PCSrcW || BranchTakenE;
            FlushE = ldr_stall || BranchTakenE;
        end
    end

    // Next-state for the wait FSM, wait timer, timeout flag and stall counter.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (MemAccessM && !DmemReadyM) begin
                    state_d = MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (DmemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = sat_inc_wait(wait_cnt_q);
                    if (wait_cnt_d == WAIT_MAX) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (mem_stall) begin
            stall_cnt_d = sat_inc_cnt(stall_cnt_q);
        end
    end

    // State registers; reset can land at any time, including mid-wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;

endmodule
